cpu_sequencer: RTL and testbench

Control sequencer for the 4-bit accumulator CPU. It runs a fixed six-state machine cycle (fetch, then execute) and decodes the instruction register's opcode into the per-cycle control word. That control word drives the load/enable pins of the PC, MAR, RAM, IR, A, B, ALU and output registers. It sits between the IR and every `register`-style datapath element, and is the only block that asserts their `load` inputs.

---
 rtl/cpu_defs_pkg.sv | 28 ++
 rtl/cpu_sequencer_t_ring.sv | 17 +
 rtl/cpu_sequencer.sv | 91 +++++++++
 tb/tb_cpu_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared opcodes, one-hot T-state constants and control-word bit indices for cpu_sequencer
package cpu_defs;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  localparam int CW_PC_INC   = 0;
  localparam int CW_PC_OE    = 1;
  localparam int CW_MAR_LOAD = 2;
  localparam int CW_RAM_OE   = 3;
  localparam int CW_IR_LOAD  = 4;
  localparam int CW_IR_OE    = 5;
  localparam int CW_A_LOAD   = 6;
  localparam int CW_A_OE     = 7;
  localparam int CW_B_LOAD   = 8;
  localparam int CW_ALU_OE   = 9;
  localparam int CW_ALU_SUB  = 10;
  localparam int CW_OUT_LOAD = 11;
  localparam int CW_N        = 12;
endpackage

// File: rtl/cpu_sequencer_t_ring.sv
// t_ring: one-hot ring counter, bit0 first; clr_n (sync, active low) -> bit0, hold freezes
//   clk, clr_n, hold in; q out (N one-hot)
module t_ring #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         hold,
  output logic [N-1:0] q
);
  logic [N-1:0] ring_q;
  always_ff @(posedge clk) begin
    if (!clr_n) ring_q <= N'(1);
    else if (!hold) ring_q <= {ring_q[N-2:0], ring_q[N-1]};
  end
  assign q = ring_q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: six T-state fetch/execute sequencer decoding the IR opcode into the control word
//   in : clk, clr_n (sync active-low clear), run (0 = stall, controls off), opcode (IR upper nibble)
//   out: tstate (one-hot, bit0 = T1), halted (sticky), control word pins,
//        pc_load only when SEQ_JMP_EN is defined (adds JMP 0110)
module cpu_sequencer
  import cpu_defs::*;
#(
  parameter int OP_W = 4,
  parameter int T_N  = 6
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  output logic [T_N-1:0]  tstate,
  output logic            halted,
  output logic            pc_inc,
  output logic            pc_oe,
  output logic            mar_load,
  output logic            ram_oe,
  output logic            ir_load,
  output logic            ir_oe,
  output logic            a_load,
  output logic            a_oe,
  output logic            b_load,
  output logic            alu_oe,
  output logic            alu_sub,
  output logic            out_load
`ifdef SEQ_JMP_EN
  ,
  output logic            pc_load
`endif
);
`ifdef SEQ_JMP_EN
  localparam logic JMP_EN = 1'b1;
`else
  localparam logic JMP_EN = 1'b0;
`endif
  logic halted_q, en, hlt_now, is_lda, is_alu, is_sub, is_jmp, is_out, is_mem;
  logic [CW_N-1:0] cw;
  assign en      = run & clr_n & ~halted_q;
  assign is_lda  = opcode == OP_LDA;
  assign is_sub  = opcode == OP_SUB;
  assign is_alu  = (opcode == OP_ADD) | is_sub;
  assign is_jmp  = JMP_EN & (opcode == OP_JMP);
  assign is_out  = opcode == OP_OUT;
  assign is_mem  = is_lda | is_alu;
  // The halting T4 edge must not advance the ring, so tstate parks on T4.
  assign hlt_now = en & (tstate == T4) & (opcode == OP_HLT);
  t_ring #(.N(T_N)) u_ring (
    .clk  (clk),
    .clr_n(clr_n),
    .hold (~en | hlt_now),
    .q    (tstate)
  );
  always_ff @(posedge clk) begin
    if (!clr_n) halted_q <= 1'b0;
    else if (hlt_now) halted_q <= 1'b1;
  end
  assign halted = halted_q;
  always_comb begin
    cw              = '0;
    cw[CW_PC_OE]    = tstate == T1;
    cw[CW_PC_INC]   = tstate == T2;
    cw[CW_MAR_LOAD] = (tstate == T1) | ((tstate == T4) & is_mem);
    cw[CW_RAM_OE]   = (tstate == T3) | ((tstate == T5) & is_mem);
    cw[CW_IR_LOAD]  = tstate == T3;
    cw[CW_IR_OE]    = (tstate == T4) & (is_mem | is_jmp);
    cw[CW_A_LOAD]   = ((tstate == T5) & is_lda) | ((tstate == T6) & is_alu);
    cw[CW_A_OE]     = (tstate == T4) & is_out;
    cw[CW_B_LOAD]   = (tstate == T5) & is_alu;
    cw[CW_ALU_OE]   = (tstate == T6) & is_alu;
    cw[CW_ALU_SUB]  = (tstate == T6) & is_sub;
    cw[CW_OUT_LOAD] = (tstate == T4) & is_out;
  end
  assign pc_inc   = en & cw[CW_PC_INC];
  assign pc_oe    = en & cw[CW_PC_OE];
  assign mar_load = en & cw[CW_MAR_LOAD];
  assign ram_oe   = en & cw[CW_RAM_OE];
  assign ir_load  = en & cw[CW_IR_LOAD];
  assign ir_oe    = en & cw[CW_IR_OE];
  assign a_load   = en & cw[CW_A_LOAD];
  assign a_oe     = en & cw[CW_A_OE];
  assign b_load   = en & cw[CW_B_LOAD];
  assign alu_oe   = en & cw[CW_ALU_OE];
  assign alu_sub  = en & cw[CW_ALU_SUB];
  assign out_load = en & cw[CW_OUT_LOAD];
`ifdef SEQ_JMP_EN
  assign pc_load  = en & (tstate == T4) & is_jmp;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer with hand-computed control words
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic clr_n, run;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic halted, pc_inc, pc_oe, mar_load, ram_oe, ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub, out_load;
  logic pc_load;
  always #5 clk = ~clk;
  cpu_sequencer dut (
    .clk(clk), .clr_n(clr_n), .run(run), .opcode(opcode), .tstate(tstate), .halted(halted),
    .pc_inc(pc_inc), .pc_oe(pc_oe), .mar_load(mar_load), .ram_oe(ram_oe), .ir_load(ir_load),
    .ir_oe(ir_oe), .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .out_load(out_load)
`ifdef SEQ_JMP_EN
    , .pc_load(pc_load)
`endif
  );
`ifndef SEQ_JMP_EN
  assign pc_load = 1'b0;
`endif
  // control word order: pc_inc pc_oe mar_load ram_oe ir_load ir_oe a_load a_oe b_load alu_oe alu_sub out_load
  typedef struct packed {
    logic [5:0]  t;
    logic        h;
    logic [11:0] cw;
    logic        pl;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] cw_dut;
  assign cw_dut = {pc_inc, pc_oe, mar_load, ram_oe, ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, alu_sub, out_load};
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk += 4;
      if (tstate !== e.t) begin n_fail++; $display("FAIL tstate got %b want %b t=%0t", tstate, e.t, $time); end
      if (halted !== e.h) begin n_fail++; $display("FAIL halted got %b want %b t=%0t", halted, e.h, $time); end
      if (cw_dut !== e.cw) begin n_fail++; $display("FAIL ctrl got %h want %h t=%0t", cw_dut, e.cw, $time); end
      if (pc_load !== e.pl) begin n_fail++; $display("FAIL pc_load got %b want %b t=%0t", pc_load, e.pl, $time); end
    end
    n_chk++;
    if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1) begin
      n_fail++;
      $display("FAIL oe_excl got %b want at most one t=%0t", {pc_oe, ram_oe, ir_oe, a_oe, alu_oe}, $time);
    end
  end
  task automatic cyc(input logic r, input logic c, input logic [3:0] op, input logic [5:0] et,
                     input logic eh, input logic [11:0] ecw, input logic epl = 1'b0);
    run = r; clr_n = c; opcode = op;
    sb.push_back('{t: et, h: eh, cw: ecw, pl: epl});
    @(posedge clk); #1;
  endtask
  task automatic fetch(input logic [3:0] op);
    cyc(1, 1, op, 6'b000001, 0, 12'h600);
    cyc(1, 1, op, 6'b000010, 0, 12'h800);
    cyc(1, 1, op, 6'b000100, 0, 12'h180);
  endtask
  task automatic instr(input logic [3:0] op, input logic [11:0] c4, input logic [11:0] c5,
                       input logic [11:0] c6, input logic pl4 = 1'b0);
    fetch(op);
    cyc(1, 1, op, 6'b001000, 0, c4, pl4);
    cyc(1, 1, op, 6'b010000, 0, c5);
    cyc(1, 1, op, 6'b100000, 0, c6);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    run = 0; clr_n = 0; opcode = 4'h0;
    @(posedge clk); #1;
    cyc(1, 0, 4'h0, 6'b000001, 0, 12'h000);
    instr(4'h0, 12'h240, 12'h120, 12'h000);
    instr(4'h2, 12'h240, 12'h108, 12'h026);
    fetch(4'h1);
    cyc(1, 1, 4'h1, 6'b001000, 0, 12'h240);
    repeat (3) cyc(0, 1, 4'h1, 6'b010000, 0, 12'h000);
    cyc(1, 1, 4'h1, 6'b010000, 0, 12'h108);
    cyc(1, 1, 4'h1, 6'b100000, 0, 12'h024);
    instr(4'hE, 12'h011, 12'h000, 12'h000);
`ifdef SEQ_JMP_EN
    instr(4'h6, 12'h040, 12'h000, 12'h000, 1'b1);
`else
    instr(4'h6, 12'h000, 12'h000, 12'h000);
`endif
    instr(4'h7, 12'h000, 12'h000, 12'h000);
    fetch(4'hF);
    cyc(0, 1, 4'hF, 6'b001000, 0, 12'h000);
    cyc(1, 1, 4'hF, 6'b001000, 0, 12'h000);
    repeat (20) cyc(1, 1, 4'hF, 6'b001000, 1, 12'h000);
    cyc(1, 1, 4'h0, 6'b001000, 1, 12'h000);
    cyc(0, 1, 4'h1, 6'b001000, 1, 12'h000);
    cyc(1, 0, 4'h0, 6'b001000, 1, 12'h000);
    cyc(1, 1, 4'h0, 6'b000001, 0, 12'h600);
    cyc(1, 1, 4'h0, 6'b000010, 0, 12'h800);
    cyc(1, 0, 4'h0, 6'b000100, 0, 12'h000);
    instr(4'h1, 12'h240, 12'h108, 12'h024);
    fetch(4'h0);
    cyc(1, 1, 4'h0, 6'b001000, 0, 12'h240);
    cyc(1, 0, 4'h0, 6'b010000, 0, 12'h000);
    cyc(1, 1, 4'h0, 6'b000001, 0, 12'h600);
    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL drain got %0d want 0 pending", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
